// File: rtl/video_timing_gen_pkg.sv
// video_timing_gen_pkg: shared pattern codes, FSM states, bar colours and the 720p60 timing preset.
package video_timing_gen_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_SOLID = 2'd2,
        PAT_CHECK = 2'd3
    } pat_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Colours are {B,G,R}
    localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] C_YELLOW  = 24'h00FFFF;
    localparam logic [23:0] C_CYAN    = 24'hFFFF00;
    localparam logic [23:0] C_GREEN   = 24'h00FF00;
    localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] C_RED     = 24'h0000FF;
    localparam logic [23:0] C_BLUE    = 24'hFF0000;
    localparam logic [23:0] C_BLACK   = 24'h000000;

    // Element 0 is the leftmost bar
    localparam logic [7:0][23:0] BAR_LUT = {
        C_BLACK, C_BLUE, C_RED, C_MAGENTA, C_GREEN, C_CYAN, C_YELLOW, C_WHITE
    };

    localparam int T720_HACTIVE = 1280;
    localparam int T720_HFP     = 110;
    localparam int T720_HSYNC   = 40;
    localparam int T720_HBP     = 220;
    localparam int T720_VACTIVE = 720;
    localparam int T720_VFP     = 5;
    localparam int T720_VSYNC   = 5;
    localparam int T720_VBP     = 20;

endpackage

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: registered test-pattern pixel source driven by the raster counters.
// Ports: i_clk/i_res clock and async reset; i_hcnt/i_vcnt raster position; i_de active pixel;
//        i_pat/i_bgr pattern and solid colour for this frame; o_data {B,G,R}, zero outside DE.
// The gradient uses i_hcnt[7:0] and the checker bit 4, so p_hcnt must be at least 8.
module video_pattern_gen
    import video_timing_gen_pkg::*;
#(
    parameter int p_hactive = T720_HACTIVE,
    parameter int p_hcnt    = 11,
    parameter int p_vcnt    = 11
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic [p_hcnt-1:0] i_hcnt,
    input  logic [p_vcnt-1:0] i_vcnt,
    input  logic              i_de,
    input  pat_e              i_pat,
    input  logic [23:0]       i_bgr,
    output logic [23:0]       o_data
);

    localparam logic [p_hcnt-1:0] c_bw_last = p_hcnt'(p_hactive / 8 - 1);

    logic [p_hcnt-1:0] r_col, w_col;
    logic [2:0]        r_bar, w_bar;
    logic              w_wrap, w_chk;
    logic [23:0]       w_px;
    logic              w_unused_v;

    // r_col/r_bar describe the previous column; counters advance every clock once
    // hcnt leaves 0, so stepping from them tracks hcnt without a divider.
    always_comb begin
        w_wrap     = r_col == c_bw_last;
        w_col      = (i_hcnt == '0 || w_wrap) ? '0 : r_col + p_hcnt'(1);
        w_bar      = (i_hcnt == '0) ? 3'd0 : !w_wrap ? r_bar : (r_bar == 3'd7) ? 3'd7 : r_bar + 3'd1;
        w_chk      = i_hcnt[4] ^ i_vcnt[4];
        w_unused_v = ^i_vcnt;
        w_px       = (i_pat == PAT_BARS)  ? BAR_LUT[w_bar] :
                     (i_pat == PAT_GRAD)  ? {3{i_hcnt[7:0]}} :
                     (i_pat == PAT_SOLID) ? i_bgr : {24{w_chk}};
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_col  <= '0;
            r_bar  <= '0;
            o_data <= '0;
        end else begin
            r_col  <= w_col;
            r_bar  <= w_bar;
            o_data <= i_de ? w_px : '0;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running video source producing vs/hs/de, test-pattern data, sof and frame count.
// Ports: i_clk pixel clock; i_res async active-high reset; i_en run request (stops only at frame end);
//        i_pat/i_bgr pattern select and solid colour, sampled at the start of each frame;
//        o_vs/o_hs/o_de syncs and data enable; o_data {B,G,R}; o_sof first-pixel pulse;
//        o_fcnt frames started; o_busy high outside IDLE. All video outputs lag the counters by 1 clock.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int   p_hactive = T720_HACTIVE,
    parameter int   p_hfp     = T720_HFP,
    parameter int   p_hsync   = T720_HSYNC,
    parameter int   p_hbp     = T720_HBP,
    parameter int   p_vactive = T720_VACTIVE,
    parameter int   p_vfp     = T720_VFP,
    parameter int   p_vsync   = T720_VSYNC,
    parameter int   p_vbp     = T720_VBP,
    parameter logic p_hs_pol  = 1'b1,
    parameter logic p_vs_pol  = 1'b1,
    parameter int   p_hcnt    = 11,
    parameter int   p_vcnt    = 11
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_en,
    input  logic [1:0]  i_pat,
    input  logic [23:0] i_bgr,
    output logic        o_vs,
    output logic        o_hs,
    output logic        o_de,
    output logic [23:0] o_data,
    output logic        o_sof,
    output logic [15:0] o_fcnt,
    output logic        o_busy
);

    localparam int c_ht = p_hactive + p_hfp + p_hsync + p_hbp;
    localparam int c_vt = p_vactive + p_vfp + p_vsync + p_vbp;

    localparam logic [p_hcnt-1:0] c_ha     = p_hcnt'(p_hactive);
    localparam logic [p_hcnt-1:0] c_hs_beg = p_hcnt'(p_hactive + p_hfp);
    localparam logic [p_hcnt-1:0] c_hs_end = p_hcnt'(p_hactive + p_hfp + p_hsync);
    localparam logic [p_hcnt-1:0] c_hlast  = p_hcnt'(c_ht - 1);
    localparam logic [p_vcnt-1:0] c_va     = p_vcnt'(p_vactive);
    localparam logic [p_vcnt-1:0] c_vs_beg = p_vcnt'(p_vactive + p_vfp);
    localparam logic [p_vcnt-1:0] c_vs_end = p_vcnt'(p_vactive + p_vfp + p_vsync);
    localparam logic [p_vcnt-1:0] c_vlast  = p_vcnt'(c_vt - 1);

    state_e            r_state, w_next;
    logic [p_hcnt-1:0] r_hcnt;
    logic [p_vcnt-1:0] r_vcnt;
    logic              w_hend, w_vend, w_run, w_origin, w_de, w_hs, w_vs, w_sof;
    logic              r_de, r_hs, r_vs, r_sof;
    logic [15:0]       r_fcnt;
    pat_e              r_pat, w_pat;
    logic [23:0]       r_bgr, w_bgr;

    always_comb begin
        w_hend   = r_hcnt == c_hlast;
        w_vend   = r_vcnt == c_vlast;
        w_run    = r_state != ST_IDLE;
        w_origin = r_hcnt == '0 && r_vcnt == '0;
        w_de     = w_run && r_hcnt < c_ha && r_vcnt < c_va;
        w_hs     = w_run && r_hcnt >= c_hs_beg && r_hcnt < c_hs_end;
        w_vs     = w_run && r_vcnt >= c_vs_beg && r_vcnt < c_vs_end;
        w_sof    = w_run && w_origin;
        // Pixel (0,0) already uses the freshly sampled pattern
        w_pat    = w_origin ? pat_e'(i_pat) : r_pat;
        w_bgr    = w_origin ? i_bgr : r_bgr;
    end

    // Once running, dropping i_en only takes effect at the last pixel of the frame;
    // a drop exactly on that pixel goes straight to IDLE instead of opening a new frame.
    always_comb begin
        w_next = r_state;
        w_next = (r_state == ST_IDLE) ? (i_en ? ST_RUN : ST_IDLE) :
                 i_en ? ST_RUN : (w_hend && w_vend) ? ST_IDLE : ST_DRAIN;
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_de    <= 1'b0;
            r_hs    <= ~p_hs_pol;
            r_vs    <= ~p_vs_pol;
            r_sof   <= 1'b0;
            r_fcnt  <= '0;
            r_pat   <= PAT_BARS;
            r_bgr   <= '0;
        end else begin
            r_state <= w_next;
            if (w_run) begin
                r_hcnt <= w_hend ? '0 : r_hcnt + p_hcnt'(1);
                if (w_hend)
                    r_vcnt <= w_vend ? '0 : r_vcnt + p_vcnt'(1);
            end
            r_de  <= w_de;
            r_hs  <= w_hs ? p_hs_pol : ~p_hs_pol;
            r_vs  <= w_vs ? p_vs_pol : ~p_vs_pol;
            r_sof <= w_sof;
            if (w_sof)
                r_fcnt <= r_fcnt + 16'd1;
            r_pat <= w_pat;
            r_bgr <= w_bgr;
        end
    end

    video_pattern_gen #(
        .p_hactive(p_hactive),
        .p_hcnt   (p_hcnt),
        .p_vcnt   (p_vcnt)
    ) u_pat (
        .i_clk (i_clk),
        .i_res (i_res),
        .i_hcnt(r_hcnt),
        .i_vcnt(r_vcnt),
        .i_de  (w_de),
        .i_pat (w_pat),
        .i_bgr (w_bgr),
        .o_data(o_data)
    );

    assign o_de   = r_de;
    assign o_hs   = r_hs;
    assign o_vs   = r_vs;
    assign o_sof  = r_sof;
    assign o_fcnt = r_fcnt;
    assign o_busy = w_run;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen on a 24x8 raster.
module tb_video_timing_gen;

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic [15:0] fcnt;
    } px_t;

    logic        i_clk, i_res, i_en;
    logic [1:0]  i_pat;
    logic [23:0] i_bgr;
    logic        o_vs, o_hs, o_de, o_sof, o_busy;
    logic [23:0] o_data;
    logic [15:0] o_fcnt;

    int  n_checks = 0;
    int  n_errors = 0;
    int  sof_seen = 0;
    px_t sb[$];

    video_timing_gen #(
        .p_hactive(16), .p_hfp(2), .p_hsync(2), .p_hbp(4),
        .p_vactive(4),  .p_vfp(1), .p_vsync(1), .p_vbp(2),
        .p_hs_pol(1'b1), .p_vs_pol(1'b1), .p_hcnt(11), .p_vcnt(11)
    ) dut (
        .i_clk(i_clk), .i_res(i_res), .i_en(i_en), .i_pat(i_pat), .i_bgr(i_bgr),
        .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_data(o_data),
        .o_sof(o_sof), .o_fcnt(o_fcnt), .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    function automatic logic [23:0] bar_rgb(input int i);
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'h00FFFF;
            2:       return 24'hFFFF00;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'h0000FF;
            6:       return 24'hFF0000;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] exp_px(input int pat, input logic [23:0] bgr, input int h, input int v);
        logic [7:0] g;
        g = 8'(h);
        case (pat)
            0:       return bar_rgb((h / 2 > 7) ? 7 : h / 2);
            1:       return {g, g, g};
            2:       return bgr;
            default: return (((h >> 4) ^ (v >> 4)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [23:0] bgr, input logic [15:0] fc);
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 16; h++)
                sb.push_back('{data: exp_px(pat, bgr, h, v), sof: (h == 0 && v == 0), fcnt: fc});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 400) begin
            tick(1);
            n++;
        end
        chk("idle_reached", o_busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_de"}, o_de, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_hs"}, o_hs, 0);
        chk({tag, "_vs"}, o_vs, 0);
        chk({tag, "_sof"}, o_sof, 0);
        chk({tag, "_fcnt"}, o_fcnt, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    // Monitor: every DE pixel is matched against the scoreboard; blanking must carry no data
    always @(negedge i_clk) begin
        px_t e;
        if (!i_res) begin
            if (o_sof) sof_seen++;
            if (o_de) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_de: got pixel 0x%0h, expected no pixel at %0t", o_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("px_data", o_data, e.data);
                    chk("px_sof", o_sof, e.sof);
                    chk("px_fcnt", o_fcnt, e.fcnt);
                end
            end else begin
                chk("blank_data", o_data, 0);
                chk("blank_sof", o_sof, 0);
            end
        end
    end

    initial begin
        int h, v;
        i_res = 1'b1; i_en = 1'b0; i_pat = 2'd0; i_bgr = 24'h0;
        tick(2);
        chk_reset_outputs("reset");
        i_res = 1'b0;
        tick(2);
        chk("idle_busy", o_busy, 0);

        // Frame 1 bars with full timing checks; pattern switched to solid mid-frame
        push_frame(0, 24'h0, 16'd1);
        push_frame(2, 24'h123456, 16'd2);
        i_en = 1'b1;
        tick(1);
        chk("lat_de", o_de, 0);
        chk("lat_busy", o_busy, 1);
        for (int k = 0; k < 192; k++) begin
            tick(1);
            h = k % 24;
            v = k / 24;
            chk("tim_de", o_de, (h < 16 && v < 4));
            chk("tim_hs", o_hs, (h >= 18 && h < 20));
            chk("tim_vs", o_vs, (v == 5));
            if (k == 0) begin
                chk("first_sof", o_sof, 1);
                chk("first_fcnt", o_fcnt, 1);
            end
            if (k == 50) begin
                i_pat = 2'd2;
                i_bgr = 24'h123456;
            end
        end

        // Frame 2: drop i_en on line 1, the frame must still complete
        tick(1);
        i_pat = 2'd1;
        tick(24);
        i_en = 1'b0;
        tick(166);
        chk("drain_busy", o_busy, 1);
        tick(1);
        chk("drain_done", o_busy, 0);
        tick(30);
        chk("idle_stays", o_busy, 0);
        chk("sof_count", sof_seen, 2);

        // Frame 3 gradient, i_en dropped then raised during DRAIN -> frame 4 back-to-back
        push_frame(1, 24'h0, 16'd3);
        push_frame(0, 24'h0, 16'd4);
        i_en = 1'b1;
        tick(2);
        i_pat = 2'd0;
        tick(48);
        i_en = 1'b0;
        tick(72);
        i_en = 1'b1;
        tick(71);
        tick(1);
        chk("b2b_sof", o_sof, 1);
        chk("b2b_fcnt", o_fcnt, 4);
        tick(24);
        i_en = 1'b0;
        wait_idle();

        // Frame counter wrap
        force dut.r_fcnt = 16'hFFFF;
        tick(1);
        release dut.r_fcnt;
        tick(1);
        chk("fcnt_preset", o_fcnt, 16'hFFFF);
        i_pat = 2'd2;
        i_bgr = 24'hABCDEF;
        push_frame(2, 24'hABCDEF, 16'd0);
        i_en = 1'b1;
        tick(2);
        chk("wrap_sof", o_sof, 1);
        chk("wrap_fcnt", o_fcnt, 0);
        tick(1);
        i_en = 1'b0;
        wait_idle();

        // Asynchronous reset mid-line after 9 pixels, then a clean restart
        for (int k = 0; k < 9; k++)
            sb.push_back('{data: 24'hABCDEF, sof: (k == 0), fcnt: 16'd1});
        i_en = 1'b1;
        tick(11);
        #2;
        i_res = 1'b1;
        #1;
        chk_reset_outputs("midres");
        chk("midres_sb", sb.size(), 0);
        i_res = 1'b0;
        push_frame(2, 24'hABCDEF, 16'd1);
        tick(2);
        chk("restart_sof", o_sof, 1);
        chk("restart_de", o_de, 1);
        chk("restart_data", o_data, 24'hABCDEF);
        tick(24);
        i_en = 1'b0;
        wait_idle();

        tick(5);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
